// File: rtl/watch_display.sv
// watch_display: consumer side of the watch time bus.
// Converts binary hour/minute to BCD using a sequential double-dabble FSM and
// drives a 4-digit multiplexed, active-low 7-segment display (HH:MM).
// Optional feature macro: LEAD_ZERO_BLANK_EN blanks the hour-tens digit when it is 0.
module watch_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour,
  input  logic [5:0] minute,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [9:0]    last_q;
  logic [13:0]   hr_sr;      // {bcd tens, bcd ones, binary} for the hour
  logic [13:0]   mn_sr;      // {bcd tens, bcd ones, binary} for the minute
  logic [2:0]    cnt;
  logic [3:0]    d3, d2, d1, d0;
  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic          changed;
  logic [3:0]    cur_nib;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;

  // One double-dabble iteration: correct each BCD nibble >=5, then shift left.
  function automatic logic [13:0] dd_step(input logic [13:0] r);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = r[13:10];
    lo = r[9:6];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi[2:0], lo, r[5:0], 1'b0};
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for a BCD nibble; non-decimal blanks.
  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign changed = ({hour, minute} != last_q);
  assign busy    = (state != IDLE);

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned
    // (which would infer a latch).
    state_nx = state;
    case (state)
      IDLE:    if (changed) state_nx = CONV;
      CONV:    if (cnt == 3'd5) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Conversion datapath: capture, six shift-and-correct steps, digit load.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      hr_sr  <= '0;
      mn_sr  <= '0;
      cnt    <= '0;
      d3     <= '0;
      d2     <= '0;
      d1     <= '0;
      d0     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (changed) begin
            last_q <= {hour, minute};
            hr_sr  <= {8'd0, 2'b00, hour};
            mn_sr  <= {8'd0, minute};
            cnt    <= '0;
          end
        end
        CONV: begin
          hr_sr <= dd_step(hr_sr);
          mn_sr <= dd_step(mn_sr);
          cnt   <= cnt + 3'd1;
        end
        LOAD: begin
          d3 <= hr_sr[13:10];
          d2 <= hr_sr[9:6];
          d1 <= mn_sr[13:10];
          d0 <= mn_sr[9:6];
        end
        default: ;
      endcase
    end
  end

  // Scan prescaler and digit index; the index advances when the prescaler wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Pattern for the digit selected by the current index.
  always_comb begin
    cur_nib = d0;
    case (idx)
      2'd0:    cur_nib = d0;
      2'd1:    cur_nib = d1;
      2'd2:    cur_nib = d2;
      default: cur_nib = d3;
    endcase
    an_nx  = ~(4'b0001 << idx);
    seg_nx = seg_enc(cur_nib);
`ifdef LEAD_ZERO_BLANK_EN
    if (idx == 2'd3 && d3 == 4'd0) seg_nx = 7'h7F;
`endif
  end

  // Registered display outputs (one cycle behind the index).
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule
